seq_multiplier: RTL and testbench
=================================

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter OP_W, default 32, operand width; only 32 supported (2*OP_W equals the 64-bit adder width).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request pulse/level; sampled only in IDLE.
REQ-005 SHALL have port a  input  32  unsigned multiplicand, sampled with accepted start.
REQ-006 SHALL have port b  input  32  unsigned multiplier, sampled with accepted start.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse; product valid in this cycle.
REQ-009 SHALL have port product  output  64  registered result a*b, held until next done.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, DONE.
REQ-011 SHALL, in IDLE with start=1, latch mcand={32'b0,a}, mplr=b, acc=0, count=0 and go to RUN.
REQ-012 SHALL ignore start in RUN and DONE; operands/state unaffected.
REQ-013 SHALL, each RUN cycle: acc <= acc+mcand if mplr[0]=1, else hold acc; mcand <<= 1; mplr >>= 1; count++.
REQ-014 SHALL perform the accumulate addition through one 64-bit adder, Cin=0, Cout discarded (sum cannot exceed 64 bits).
REQ-015 SHALL execute exactly 32 RUN cycles (count 0..31), no early termination on mplr=0.
REQ-016 SHALL, on the last RUN cycle, write the final acc value into product and go to DONE.
REQ-017 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE.
REQ-018 SHALL give fixed latency: start accepted at edge ending cycle 0 -> RUN cycles 1..32 -> done=1 in cycle 33.
REQ-019 SHALL accept a new start in the first IDLE cycle after DONE (cycle 34), giving 34-cycle throughput.
REQ-020 SHALL keep product stable between done pulses; product changes only on the REQ-016 edge.
REQ-021 SHALL drive busy=1 in RUN and DONE, busy=0 in IDLE.

Reset
REQ-022 SHALL, while rst=1 at a rising edge, set state=IDLE, busy=0, done=0, product=0, acc=0, mcand=0, mplr=0, count=0.
REQ-023 SHALL give rst priority over start and over all FSM transitions.
REQ-024 SHALL, on rst mid-RUN or in DONE, abort with no done pulse; product reads 0 after reset.
REQ-025 SHALL accept a start in the first cycle after rst deasserts.

Structure
REQ-026 SHALL place state encodings (IDLE, RUN, DONE), OP_W=32, and CNT_W=5 in shared package rv_mul_pkg.
REQ-027 SHALL instantiate exactly one sub-module, FullAdder64, as the accumulate adder; no other arithmetic operator on acc.
REQ-028 SHALL register all outputs; no combinational path from inputs to outputs.

Verification
REQ-029 SHALL cover a=3, b=5, start in cycle 0 -> done=1 in cycle 33, product=64'h0000_0000_0000_000F, busy=0 in cycle 34.
REQ-030 SHALL cover a=b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001 at done.
REQ-031 SHALL cover a=0, b=32'h1234_5678 -> product=0, done still in cycle 33 (no early exit).
REQ-032 SHALL cover start held high with a=7,b=9 changing to a=2,b=2 during RUN -> product=63, exactly one done per accepted start.
REQ-033 SHALL cover rst=1 in cycle 10 of a RUN -> busy=0 in cycle 11, no done, product=0; new start a=6,b=7 -> product=42 after 33 cycles.
REQ-034 SHALL cover back-to-back: second start (a=10,b=10) in cycle 34 after first done -> product=100 with done in cycle 67.

Source files
------------

// File: rtl/rv_mul_pkg.sv
// rtl/rv_mul_pkg.sv - shared types and sizes for the sequential multiplier
package rv_mul_pkg;

  localparam int OP_W  = 32;
  localparam int CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FullAdder64.sv
// rtl/FullAdder64.sv - 64-bit ripple-free adder used as the accumulate adder
module FullAdder64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  // Plain 65-bit addition; carry out is exposed separately from the sum.
  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {64'd0, cin};

endmodule

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - shift-and-add unsigned multiplier, 32 iterations per product
module seq_multiplier
  import rv_mul_pkg::*;
#(
  parameter int OP_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*OP_W-1:0] product
);

  state_t              state;
  state_t              next_state;
  logic [2*OP_W-1:0]   mcand;
  logic [OP_W-1:0]     mplr;
  logic [2*OP_W-1:0]   acc;
  logic [CNT_W-1:0]    count;
  logic [2*OP_W-1:0]   addend;
  logic [2*OP_W-1:0]   sum;
  logic                add_cout_unused;
  logic                last_run;

  // A zero addend makes the adder output equal acc, so acc can load sum every RUN cycle.
  assign addend   = mplr[0] ? mcand : '0;
  assign last_run = (state == RUN) && (count == CNT_W'(OP_W - 1));

  FullAdder64 u_adder (
    .a    (acc),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (add_cout_unused)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: fixed 32 RUN cycles, one DONE cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (last_run) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Status outputs registered from the upcoming state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (next_state != IDLE);
      done <= (next_state == DONE);
    end
  end

  // Datapath: operand capture in IDLE, one shift-and-add step per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      mplr    <= '0;
      acc     <= '0;
      count   <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= {{OP_W{1'b0}}, a};
            mplr  <= b;
            acc   <= '0;
            count <= '0;
          end
        end
        RUN: begin
          acc   <= sum;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          count <= count + CNT_W'(1);
          if (last_run) product <= sum;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - randomized self-checking bench for seq_multiplier
module tb_seq_multiplier;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int          errors;
  int          checks;
  logic [63:0] model_product;

  seq_multiplier #(.OP_W(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One multiplication: start in cycle 0, watch cycles 1..34.
  task automatic run_op(input string name, input logic [31:0] a1, input logic [31:0] b1,
                        input bit hold, input logic [31:0] a2, input logic [31:0] b2);
    logic [63:0] exp;
    int early_done;
    int not_busy;
    int moved;
    exp = {32'd0, a1} * {32'd0, b1};
    early_done = 0;
    not_busy = 0;
    moved = 0;
    a = a1;
    b = b1;
    start = 1'b1;
    tick();
    for (int c = 1; c <= 32; c++) begin
      if (hold) begin
        a = a2; b = b2; start = 1'b1;
      end else begin
        a = $urandom; b = $urandom; start = 1'($urandom_range(0, 1));
      end
      if (done !== 1'b0) early_done++;
      if (busy !== 1'b1) not_busy++;
      if (product !== model_product) moved++;
      tick();
    end
    checks++;
    if (early_done != 0) begin
      errors++; $display("FAIL %s early_done: got %0d cycles with done, want 0", name, early_done);
    end
    checks++;
    if (not_busy != 0) begin
      errors++; $display("FAIL %s busy_in_run: got %0d idle cycles, want 0", name, not_busy);
    end
    checks++;
    if (moved != 0) begin
      errors++; $display("FAIL %s product_hold: changed in %0d cycles, want 0", name, moved);
    end
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL %s done_c33: got %b want 1", name, done);
    end
    checks++;
    if (product !== exp) begin
      errors++; $display("FAIL %s product: got %h want %h", name, product, exp);
    end
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_c33: got %b want 1", name, busy);
    end
    model_product = exp;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s idle_c34: got busy=%b done=%b want 0 0", name, busy, done);
    end
    checks++;
    if (product !== exp) begin
      errors++; $display("FAIL %s product_c34: got %h want %h", name, product, exp);
    end
    start = 1'b0;
    a = '0;
    b = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 32'd5; b = 32'd5;
    tick(); tick(); tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (product !== 64'd0) begin
      errors++; $display("FAIL reset_product: got %h want 0", product);
    end
    model_product = '0;
    rst = 1'b0; start = 1'b0;
  endtask

  task automatic test_directed();
    run_op("basic_3x5", 32'd3, 32'd5, 1'b0, 32'd0, 32'd0);
    run_op("max_ffff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd0);
    run_op("zero_mcand", 32'd0, 32'h1234_5678, 1'b0, 32'd0, 32'd0);
    run_op("start_held", 32'd7, 32'd9, 1'b1, 32'd2, 32'd2);
  endtask

  task automatic test_reset_mid_run();
    int stray;
    stray = 0;
    a = 32'hDEAD_BEEF; b = 32'h0000_0F0F; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL midrun_reset_status: got busy=%b done=%b want 0 0", busy, done);
    end
    checks++;
    if (product !== 64'd0) begin
      errors++; $display("FAIL midrun_reset_product: got %h want 0", product);
    end
    model_product = '0;
    for (int c = 0; c < 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0) stray++;
      tick();
    end
    checks++;
    if (stray != 0) begin
      errors++; $display("FAIL midrun_reset_abort: got %0d active cycles, want 0", stray);
    end
    run_op("after_reset_6x7", 32'd6, 32'd7, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_reset_in_done();
    a = 32'd11; b = 32'd13; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (32) tick();
    checks++;
    if (done !== 1'b1) begin
      errors++; $display("FAIL done_reset_pre: got done=%b want 1", done);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || product !== 64'd0) begin
      errors++; $display("FAIL done_reset: got busy=%b done=%b product=%h want 0 0 0", busy, done, product);
    end
    model_product = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    run_op("b2b_first", 32'd12, 32'd3, 1'b0, 32'd0, 32'd0);
    run_op("b2b_10x10", 32'd10, 32'd10, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op("random", $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    model_product = '0;
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    test_reset();
    test_directed();
    test_reset_mid_run();
    test_reset_in_done();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
